// File: rtl/umi_req_encode_pkg.sv
// Shared UMI message constants: request/response opcodes, atomic subtypes,
// host operation encoding and command word field offsets.
package umi_req_encode_pkg;

  localparam logic [7:0] UMI_REQ_READ    = 8'h01;
  localparam logic [7:0] UMI_REQ_WRITE   = 8'h03;
  localparam logic [7:0] UMI_REQ_POSTED  = 8'h05;
  localparam logic [7:0] UMI_REQ_ATOMIC  = 8'h09;
  localparam logic [7:0] UMI_RESP_READ   = 8'h02;
  localparam logic [7:0] UMI_RESP_WRITE  = 8'h04;

  localparam logic [7:0] UMI_ATOMIC_ADD  = 8'h00;
  localparam logic [7:0] UMI_ATOMIC_AND  = 8'h01;
  localparam logic [7:0] UMI_ATOMIC_OR   = 8'h02;
  localparam logic [7:0] UMI_ATOMIC_XOR  = 8'h03;
  localparam logic [7:0] UMI_ATOMIC_MAX  = 8'h04;
  localparam logic [7:0] UMI_ATOMIC_MIN  = 8'h05;
  localparam logic [7:0] UMI_ATOMIC_MAXU = 8'h06;
  localparam logic [7:0] UMI_ATOMIC_MINU = 8'h07;
  localparam logic [7:0] UMI_ATOMIC_SWAP = 8'h08;

  typedef enum logic [2:0] {
    HOST_READ   = 3'd0,
    HOST_WRITE  = 3'd1,
    HOST_POSTED = 3'd2,
    HOST_ATOMIC = 3'd3
  } host_op_e;

  localparam int unsigned CMD_OPC_LSB  = 0;
  localparam int unsigned CMD_LEN_LSB  = 8;
  localparam int unsigned CMD_SIZE_LSB = 16;

  function automatic logic [7:0] req_opcode(input logic [2:0] op);
    logic [7:0] opc;
    opc = '0;
    case (op)
      HOST_READ:   opc = UMI_REQ_READ;
      HOST_WRITE:  opc = UMI_REQ_WRITE;
      HOST_POSTED: opc = UMI_REQ_POSTED;
      HOST_ATOMIC: opc = UMI_REQ_ATOMIC;
      default:     opc = '0;
    endcase
    return opc;
  endfunction

  function automatic logic is_resp_opcode(input logic [7:0] opc);
    return (opc == UMI_RESP_READ) || (opc == UMI_RESP_WRITE);
  endfunction

endpackage

// File: rtl/umi_req_encode_credit.sv
// Saturating up/down counter of outstanding non-posted requests, with a
// registered flag for a decrement that arrives with nothing outstanding.
module umi_credit_counter
  import umi_req_encode_pkg::*;
#(
  parameter int unsigned MAXOUT = 8,
  parameter int unsigned OW     = $clog2(MAXOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [OW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err_underflow
);

  logic inc_ok;
  logic dec_ok;

  assign full  = (count == OW'(MAXOUT));
  assign empty = (count == '0);

  // A decrement at zero is still legal when paired with a same-cycle
  // increment; the pair nets to no change.
  assign inc_ok = inc & ~full;
  assign dec_ok = dec & (~empty | inc_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      err_underflow <= dec & ~dec_ok;
      case ({inc_ok, dec_ok})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/umi_req_encode.sv
// Host-side UMI request encoder: builds the command word, issues it through
// a one-deep registered stage and limits outstanding non-posted requests.
module umi_req_encode
  import umi_req_encode_pkg::*;
#(
  parameter int unsigned CW     = 32,
  parameter int unsigned AW     = 64,
  parameter int unsigned DW     = 64,
  parameter int unsigned MAXOUT = 8,
  parameter int unsigned OW     = $clog2(MAXOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [2:0]    host_op,
  input  logic [7:0]    host_atype,
  input  logic [7:0]    host_len,
  input  logic [3:0]    host_size,
  input  logic [AW-1:0] host_dstaddr,
  input  logic [AW-1:0] host_srcaddr,
  input  logic [DW-1:0] host_data,
  output logic          umi_out_valid,
  input  logic          umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_resp_valid,
  input  logic [CW-1:0] umi_resp_cmd,
  output logic [OW-1:0] outstanding,
  output logic          err_illegal,
  output logic          err_unexpected
);

  logic          stage_free;
  logic          credit_ok;
  logic          op_illegal;
  logic          op_posted;
  logic          accept;
  logic          count_inc;
  logic          resp_ok;
  logic          resp_bad_q;
  logic          err_underflow;
  logic          cnt_full;
  logic          cnt_empty;
  logic [CW-1:0] cmd_next;

  assign op_illegal = (host_op > 3'(HOST_ATOMIC));
  assign op_posted  = (host_op == 3'(HOST_POSTED));
  assign stage_free = ~umi_out_valid | umi_out_ready;
  assign credit_ok  = ~cnt_full;
  assign host_ready = stage_free & (credit_ok | op_posted | op_illegal);
  assign accept     = host_valid & host_ready;
  assign count_inc  = accept & ~op_illegal & ~op_posted;
  assign resp_ok    = is_resp_opcode(umi_resp_cmd[7:0]);

  always_comb begin
    cmd_next = '0;
    cmd_next[CMD_OPC_LSB +: 8]  = req_opcode(host_op);
    cmd_next[CMD_LEN_LSB +: 8]  = (host_op == 3'(HOST_ATOMIC)) ? host_atype : host_len;
    cmd_next[CMD_SIZE_LSB +: 4] = host_size;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      umi_out_valid   <= 1'b0;
      umi_out_cmd     <= '0;
      umi_out_dstaddr <= '0;
      umi_out_srcaddr <= '0;
      umi_out_data    <= '0;
      err_illegal     <= 1'b0;
      resp_bad_q      <= 1'b0;
    end else begin
      err_illegal <= accept & op_illegal;
      resp_bad_q  <= umi_resp_valid & ~resp_ok;
      if (accept && !op_illegal) begin
        umi_out_valid   <= 1'b1;
        umi_out_cmd     <= cmd_next;
        umi_out_dstaddr <= host_dstaddr;
        umi_out_srcaddr <= host_srcaddr;
        umi_out_data    <= host_data;
      end else if (umi_out_ready) begin
        umi_out_valid <= 1'b0;
      end
    end
  end

  umi_credit_counter #(
    .MAXOUT (MAXOUT),
    .OW     (OW)
  ) u_credit (
    .clk           (clk),
    .reset         (reset),
    .inc           (count_inc),
    .dec           (umi_resp_valid & resp_ok),
    .count         (outstanding),
    .full          (cnt_full),
    .empty         (cnt_empty),
    .err_underflow (err_underflow)
  );

  assign err_unexpected = err_underflow | resp_bad_q;

endmodule

// File: tb/tb_umi_req_encode.sv
// Directed bench for umi_req_encode: a vector table for single-cycle
// transactions plus sequences for credit limit, backpressure and reset.
module tb_umi_req_encode;

  localparam int unsigned CW = 32;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned MAXOUT = 8;
  localparam int unsigned OW = $clog2(MAXOUT + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          host_valid;
  logic          host_ready;
  logic [2:0]    host_op;
  logic [7:0]    host_atype;
  logic [7:0]    host_len;
  logic [3:0]    host_size;
  logic [AW-1:0] host_dstaddr;
  logic [AW-1:0] host_srcaddr;
  logic [DW-1:0] host_data;
  logic          umi_out_valid;
  logic          umi_out_ready;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic          umi_resp_valid;
  logic [CW-1:0] umi_resp_cmd;
  logic [OW-1:0] outstanding;
  logic          err_illegal;
  logic          err_unexpected;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  umi_req_encode #(
    .CW     (CW),
    .AW     (AW),
    .DW     (DW),
    .MAXOUT (MAXOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .host_op         (host_op),
    .host_atype      (host_atype),
    .host_len        (host_len),
    .host_size       (host_size),
    .host_dstaddr    (host_dstaddr),
    .host_srcaddr    (host_srcaddr),
    .host_data       (host_data),
    .umi_out_valid   (umi_out_valid),
    .umi_out_ready   (umi_out_ready),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_resp_valid  (umi_resp_valid),
    .umi_resp_cmd    (umi_resp_cmd),
    .outstanding     (outstanding),
    .err_illegal     (err_illegal),
    .err_unexpected  (err_unexpected)
  );

  typedef struct {
    logic        hv;
    logic [2:0]  op;
    logic [7:0]  atype;
    logic [7:0]  len;
    logic [3:0]  size;
    logic [63:0] dst;
    logic [63:0] data;
    logic        rv;
    logic [7:0]  rop;
    logic        e_valid;
    logic [31:0] e_cmd;
    logic [3:0]  e_out;
    logic        e_ill;
    logic        e_unexp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic hv, input logic [2:0] op, input logic [7:0] atype,
                              input logic [7:0] len, input logic [3:0] size,
                              input logic [63:0] dst, input logic [63:0] data,
                              input logic rv, input logic [7:0] rop,
                              input logic e_valid, input logic [31:0] e_cmd,
                              input logic [3:0] e_out, input logic e_ill, input logic e_unexp);
    vec_t v;
    v.hv = hv; v.op = op; v.atype = atype; v.len = len; v.size = size;
    v.dst = dst; v.data = data; v.rv = rv; v.rop = rop;
    v.e_valid = e_valid; v.e_cmd = e_cmd; v.e_out = e_out;
    v.e_ill = e_ill; v.e_unexp = e_unexp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic hv, input logic [2:0] op, input logic [7:0] atype,
                       input logic [7:0] len, input logic [3:0] size,
                       input logic [63:0] dst, input logic [63:0] data,
                       input logic rv, input logic [7:0] rop);
    @(negedge clk);
    host_valid     = hv;
    host_op        = op;
    host_atype     = atype;
    host_len       = len;
    host_size      = size;
    host_dstaddr   = dst;
    host_srcaddr   = dst + 64'h8;
    host_data      = data;
    umi_resp_valid = rv;
    umi_resp_cmd   = {24'h0, rop};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    host_valid = 1'b0;
    umi_resp_valid = 1'b0;
    umi_out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1, 3'd0, 8'h00, 8'h03, 4'd2, 64'h1000, 64'h11, 0, 8'h00, 1, 32'h00020301, 4'd1, 0, 0);
    vecs[1]  = mk(1, 3'd3, 8'h04, 8'hFF, 4'd3, 64'h2000, 64'h22, 0, 8'h00, 1, 32'h00030409, 4'd2, 0, 0);
    vecs[2]  = mk(1, 3'd2, 8'h00, 8'h00, 4'd3, 64'h3000, 64'h33, 0, 8'h00, 1, 32'h00030005, 4'd2, 0, 0);
    vecs[3]  = mk(1, 3'd1, 8'h00, 8'h07, 4'd0, 64'h4000, 64'h44, 0, 8'h00, 1, 32'h00000703, 4'd3, 0, 0);
    vecs[4]  = mk(0, 3'd0, 8'h00, 8'h00, 4'd0, 64'h0,    64'h0,  1, 8'h02, 0, 32'h0,        4'd2, 0, 0);
    vecs[5]  = mk(1, 3'd6, 8'h00, 8'h00, 4'd0, 64'h5000, 64'h55, 0, 8'h00, 0, 32'h0,        4'd2, 1, 0);
    vecs[6]  = mk(0, 3'd0, 8'h00, 8'h00, 4'd0, 64'h0,    64'h0,  1, 8'h05, 0, 32'h0,        4'd2, 0, 1);
    vecs[7]  = mk(0, 3'd0, 8'h00, 8'h00, 4'd0, 64'h0,    64'h0,  1, 8'h04, 0, 32'h0,        4'd1, 0, 0);
    vecs[8]  = mk(1, 3'd0, 8'h00, 8'h01, 4'd1, 64'h6000, 64'h66, 1, 8'h02, 1, 32'h00010101, 4'd1, 0, 0);
    vecs[9]  = mk(0, 3'd0, 8'h00, 8'h00, 4'd0, 64'h0,    64'h0,  1, 8'h04, 0, 32'h0,        4'd0, 0, 0);
    vecs[10] = mk(0, 3'd0, 8'h00, 8'h00, 4'd0, 64'h0,    64'h0,  1, 8'h04, 0, 32'h0,        4'd0, 0, 1);
    vecs[11] = mk(1, 3'd0, 8'h00, 8'h00, 4'd0, 64'h7000, 64'h77, 1, 8'h02, 1, 32'h00000001, 4'd0, 0, 0);

    reset = 1'b1;
    host_valid = 1'b0; host_op = '0; host_atype = '0; host_len = '0; host_size = '0;
    host_dstaddr = '0; host_srcaddr = '0; host_data = '0;
    umi_out_ready = 1'b1; umi_resp_valid = 1'b0; umi_resp_cmd = '0;
    tick();
    tick();
    chk("rst_valid", 64'(umi_out_valid), 64'h0);
    chk("rst_cmd", 64'(umi_out_cmd), 64'h0);
    chk("rst_dst", umi_out_dstaddr, 64'h0);
    chk("rst_out", 64'(outstanding), 64'h0);
    chk("rst_errs", 64'({err_illegal, err_unexpected}), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].hv, vecs[i].op, vecs[i].atype, vecs[i].len, vecs[i].size,
            vecs[i].dst, vecs[i].data, vecs[i].rv, vecs[i].rop);
      tick();
      chk($sformatf("v%0d_valid", i), 64'(umi_out_valid), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d_out", i), 64'(outstanding), 64'(vecs[i].e_out));
      chk($sformatf("v%0d_ill", i), 64'(err_illegal), 64'(vecs[i].e_ill));
      chk($sformatf("v%0d_unexp", i), 64'(err_unexpected), 64'(vecs[i].e_unexp));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_cmd", i), 64'(umi_out_cmd), 64'(vecs[i].e_cmd));
        chk($sformatf("v%0d_dst", i), umi_out_dstaddr, vecs[i].dst);
        chk($sformatf("v%0d_src", i), umi_out_srcaddr, vecs[i].dst + 64'h8);
        chk($sformatf("v%0d_data", i), umi_out_data, vecs[i].data);
      end
    end

    // Credit limit: eight writes fill the counter; posted still flows.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'd1, 8'h00, 8'h00, 4'd3, 64'h100 + 64'(i), 64'(i), 0, 8'h00);
      tick();
    end
    chk("cr_out_full", 64'(outstanding), 64'd8);
    drive(0, 3'd1, 8'h00, 8'h00, 4'd0, 64'h0, 64'h0, 0, 8'h00);
    #1 chk("cr_ready_write", 64'(host_ready), 64'h0);
    drive(1, 3'd2, 8'h00, 8'h00, 4'd0, 64'h900, 64'h99, 0, 8'h00);
    #1 chk("cr_ready_posted", 64'(host_ready), 64'h1);
    tick();
    chk("cr_posted_cmd", 64'(umi_out_cmd), 64'h00000005);
    chk("cr_posted_out", 64'(outstanding), 64'd8);
    drive(0, 3'd1, 8'h00, 8'h00, 4'd0, 64'h0, 64'h0, 1, 8'h04);
    #1 chk("cr_ready_same_cycle", 64'(host_ready), 64'h0);
    tick();
    umi_resp_valid = 1'b0;
    chk("cr_out_after_resp", 64'(outstanding), 64'd7);
    chk("cr_ready_reenabled", 64'(host_ready), 64'h1);

    // Backpressure: a held packet stays stable and blocks new accepts.
    do_reset();
    umi_out_ready = 1'b0;
    drive(1, 3'd0, 8'h00, 8'h00, 4'd2, 64'hAAAA0000, 64'h55, 0, 8'h00);
    tick();
    chk("bp_first_valid", 64'(umi_out_valid), 64'h1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'd1, 8'h00, 8'h03, 4'd3, 64'hBBBB0000, 64'h66, 0, 8'h00);
      #1 chk($sformatf("bp_ready_%0d", i), 64'(host_ready), 64'h0);
      tick();
      chk($sformatf("bp_cmd_%0d", i), 64'(umi_out_cmd), 64'h00020001);
      chk($sformatf("bp_dst_%0d", i), umi_out_dstaddr, 64'hAAAA0000);
      chk($sformatf("bp_valid_%0d", i), 64'(umi_out_valid), 64'h1);
    end
    drive(1, 3'd1, 8'h00, 8'h03, 4'd3, 64'hBBBB0000, 64'h66, 0, 8'h00);
    umi_out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(host_ready), 64'h1);
    tick();
    chk("bp_new_cmd", 64'(umi_out_cmd), 64'h00030303);
    chk("bp_new_dst", umi_out_dstaddr, 64'hBBBB0000);
    chk("bp_out", 64'(outstanding), 64'd2);

    // Reset during a stall drops the held packet and clears the count.
    drive(0, 3'd0, 8'h00, 8'h00, 4'd0, 64'h0, 64'h0, 0, 8'h00);
    umi_out_ready = 1'b0;
    tick();
    chk("mr_held_valid", 64'(umi_out_valid), 64'h1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("mr_valid", 64'(umi_out_valid), 64'h0);
    chk("mr_out", 64'(outstanding), 64'h0);
    chk("mr_cmd", 64'(umi_out_cmd), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
